// File: rtl/immgen_pipe.sv
// immgen_pipe
//   Pipelined RV32I/RV64I immediate generator. Decodes the immediate of an
//   I/S/B/U/J instruction, sign-extends it to XLEN and, for branches, JAL
//   and AUIPC, adds it to the instruction PC. Results leave through a
//   valid/ready handshake backed by a main output register and one skid
//   register. Unrecognised opcodes are flagged and counted (saturating).
//
// Parameters
//   XLEN   datapath width, 32 or 64
//   CNT_W  width of the illegal-instruction counter
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     instruction word and PC valid
//   in_ready     block can accept this cycle (registered state, not OUT_READY)
//   in           32-bit instruction word
//   in_pc        PC of the instruction
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out          sign-extended immediate
//   out_target   in_pc + immediate for B/J/AUIPC, 0 otherwise
//   out_fmt      0=R/none 1=I 2=S 3=B 4=U 5=J 7=illegal
//   out_illegal  opcode not recognised
//   illegal_cnt  saturating count of accepted illegal instructions
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out,
  output logic [XLEN-1:0]  out_target,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic [2:0]      fmt;
    logic            ill;
  } res_t;

  // Size cast of a signed operand sign-extends, so bit 31 fills the upper
  // half when XLEN=64 and the cast is a no-op when XLEN=32.
  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // PC-relative target wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_add(input logic [XLEN-1:0] pc,
                                             input logic signed [XLEN-1:0] imm);
    return pc + $unsigned(imm);
  endfunction

  // Counter saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic signed [31:0]     imm32_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic                   pcrel_p0;
  res_t                   res_p0;

  res_t                   res_p1;
  logic                   vld_p1;
  res_t                   skid_p1;
  logic                   skid_vld_p1;
  logic [CNT_W-1:0]       cnt_p1;

  logic                   accept;
  logic                   drain;

  // ---- stage p0: combinational decode of the incoming word ----
  always_comb begin
    imm32_p0     = '0;
    pcrel_p0     = 1'b0;
    res_p0.fmt   = FMT_R;
    res_p0.ill   = 1'b0;
    unique case (in[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        res_p0.fmt = FMT_I;
        imm32_p0   = {{20{in[31]}}, in[31:20]};
      end
      OP_STORE: begin
        res_p0.fmt = FMT_S;
        imm32_p0   = {{20{in[31]}}, in[31:25], in[11:7]};
      end
      OP_BRANCH: begin
        res_p0.fmt = FMT_B;
        pcrel_p0   = 1'b1;
        imm32_p0   = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      end
      OP_LUI: begin
        res_p0.fmt = FMT_U;
        imm32_p0   = {in[31:12], 12'b0};
      end
      OP_AUIPC: begin
        res_p0.fmt = FMT_U;
        pcrel_p0   = 1'b1;
        imm32_p0   = {in[31:12], 12'b0};
      end
      OP_JAL: begin
        res_p0.fmt = FMT_J;
        pcrel_p0   = 1'b1;
        imm32_p0   = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      end
      OP_OP: begin
        res_p0.fmt = FMT_R;
      end
      default: begin
        res_p0.fmt = FMT_ILL;
        res_p0.ill = 1'b1;
      end
    endcase
    imm_p0     = sext32(imm32_p0);
    res_p0.imm = imm_p0;
    res_p0.tgt = pcrel_p0 ? pc_add(in_pc, imm_p0) : '0;
  end

  // Readiness depends only on skid occupancy and reset, never on out_ready.
  assign in_ready = !skid_vld_p1 && !reset;
  assign accept   = in_valid && in_ready;
  assign drain    = vld_p1 && out_ready;

  // ---- stage p1: main output register, skid register, counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      res_p1      <= '0;
      cnt_p1      <= '0;
    end else begin
      // Skid always holds the younger entry, so it refills main first.
      if (drain && skid_vld_p1) begin
        res_p1      <= skid_p1;
        skid_vld_p1 <= 1'b0;
      end else if (accept && (!vld_p1 || drain)) begin
        res_p1 <= res_p0;
      end else if (accept) begin
        skid_vld_p1 <= 1'b1;
      end
      vld_p1 <= accept || skid_vld_p1 || (vld_p1 && !drain);
      if (accept && res_p0.ill) begin
        cnt_p1 <= sat_inc(cnt_p1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && vld_p1 && !drain) begin
      skid_p1 <= res_p0;
    end
  end

  assign out_valid   = vld_p1;
  assign out         = res_p1.imm;
  assign out_target  = res_p1.tgt;
  assign out_fmt     = res_p1.fmt;
  assign out_illegal = res_p1.ill;
  assign illegal_cnt = cnt_p1;

endmodule

// File: tb/tb_immgen_pipe.sv
// Testbench for immgen_pipe: one XLEN=32/CNT_W=8 instance and one
// XLEN=64/CNT_W=2 instance. Vectors come from tables of expected results;
// accepted inputs are pushed to a scoreboard queue and popped when the
// DUT hands a result over.
module tb_immgen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_illegal32;
  logic [31:0] in32, pc32, out32, tgt32;
  logic [2:0]  fmt32;
  logic [7:0]  cnt32;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, out_illegal64;
  logic [31:0] in64;
  logic [63:0] pc64, out64, tgt64;
  logic [2:0]  fmt64;
  logic [1:0]  cnt64;

  immgen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
    .clk(clk), .reset(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .in(in32), .in_pc(pc32), .out_valid(out_valid32), .out_ready(out_ready32),
    .out(out32), .out_target(tgt32), .out_fmt(fmt32), .out_illegal(out_illegal32),
    .illegal_cnt(cnt32)
  );

  immgen_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .reset(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .in(in64), .in_pc(pc64), .out_valid(out_valid64), .out_ready(out_ready64),
    .out(out64), .out_target(tgt64), .out_fmt(fmt64), .out_illegal(out_illegal64),
    .illegal_cnt(cnt64)
  );

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t q32[$];
  vec_t q64[$];
  vec_t cur32, cur64;
  vec_t t32[15];
  vec_t t64[4];
  int   checks = 0;
  int   failures = 0;
  bit   acc32, acc64;

  function automatic vec_t mk(input logic [31:0] ins, input logic [63:0] pc,
                              input logic [63:0] imm, input logic [63:0] tgt,
                              input logic [2:0] fmt, input logic ill);
    vec_t v;
    v.ins = ins; v.pc = pc; v.imm = imm; v.tgt = tgt; v.fmt = fmt; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  // One clock cycle: sample at the falling edge, then advance past the
  // rising edge so the caller sees post-edge state.
  task automatic step();
    vec_t e;
    @(negedge clk);
    acc32 = 1'b0;
    acc64 = 1'b0;
    if (out_valid32 && out_ready32) begin
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL x32 spurious output: out=0x%0h with nothing pending", out32);
      end else begin
        e = q32.pop_front();
        chk("x32 imm", 64'(out32), 64'(e.imm[31:0]));
        chk("x32 target", 64'(tgt32), 64'(e.tgt[31:0]));
        chk("x32 fmt", 64'(fmt32), 64'(e.fmt));
        chk("x32 illegal", 64'(out_illegal32), 64'(e.ill));
      end
    end
    if (in_valid32 && in_ready32) begin
      q32.push_back(cur32);
      acc32 = 1'b1;
    end
    if (out_valid64 && out_ready64) begin
      if (q64.size() == 0) begin
        checks++; failures++;
        $display("FAIL x64 spurious output: out=0x%0h with nothing pending", out64);
      end else begin
        e = q64.pop_front();
        chk("x64 imm", out64, e.imm);
        chk("x64 target", tgt64, e.tgt);
        chk("x64 fmt", 64'(fmt64), 64'(e.fmt));
        chk("x64 illegal", 64'(out_illegal64), 64'(e.ill));
      end
    end
    if (in_valid64 && in_ready64) begin
      q64.push_back(cur64);
      acc64 = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input vec_t v);
    cur32 = v; in32 = v.ins; pc32 = v.pc[31:0]; in_valid32 = 1'b1;
  endtask

  task automatic drive64(input vec_t v);
    cur64 = v; in64 = v.ins; pc64 = v.pc; in_valid64 = 1'b1;
  endtask

  task automatic send32(input vec_t v);
    int n = 0;
    drive32(v);
    do begin step(); n++; end while (!acc32 && n < 20);
    if (!acc32) bound_fail("x32 accept");
    in_valid32 = 1'b0;
  endtask

  task automatic send64(input vec_t v);
    int n = 0;
    drive64(v);
    do begin step(); n++; end while (!acc64 && n < 20);
    if (!acc64) bound_fail("x64 accept");
    in_valid64 = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 20) begin step(); n++; end
    chk("x32 drained", 64'(q32.size()), 64'd0);
    chk("x64 drained", 64'(q64.size()), 64'd0);
  endtask

  initial begin
    int ic;
    int n;
    t32[0]  = mk(32'hFFF00003, 64'h0,    64'hFFFFFFFF, 64'h0,        3'd1, 1'b0);
    t32[1]  = mk(32'hFE001023, 64'h0,    64'hFFFFFFE0, 64'h0,        3'd2, 1'b0);
    t32[2]  = mk(32'h00001003, 64'h0,    64'h0,        64'h0,        3'd1, 1'b0);
    t32[3]  = mk(32'hFE001063, 64'h100,  64'hFFFFF7E0, 64'hFFFFF8E0, 3'd3, 1'b0);
    t32[4]  = mk(32'h0080006F, 64'h1000, 64'h8,        64'h1008,     3'd5, 1'b0);
    t32[5]  = mk(32'h123450B7, 64'h40,   64'h12345000, 64'h0,        3'd4, 1'b0);
    t32[6]  = mk(32'hFFFFFFFF, 64'h80,   64'h0,        64'h0,        3'd7, 1'b1);
    t32[7]  = mk(32'h00B50533, 64'h40,   64'h0,        64'h0,        3'd0, 1'b0);
    t32[8]  = mk(32'hFFFFF517, 64'h2000, 64'hFFFFF000, 64'h1000,     3'd4, 1'b0);
    t32[9]  = mk(32'h00008067, 64'h300,  64'h0,        64'h0,        3'd1, 1'b0);
    t32[10] = mk(32'h00000073, 64'h304,  64'h0,        64'h0,        3'd1, 1'b0);
    t32[11] = mk(32'h7FF00093, 64'h0,    64'h7FF,      64'h0,        3'd1, 1'b0);
    t32[12] = mk(32'h00000863, 64'h200,  64'h10,       64'h210,      3'd3, 1'b0);
    t32[13] = mk(32'hFFDFF06F, 64'h1000, 64'hFFFFFFFC, 64'hFFC,      3'd5, 1'b0);
    t32[14] = mk(32'h0000000B, 64'h10,   64'h0,        64'h0,        3'd7, 1'b1);
    t64[0]  = mk(32'h800000B7, 64'h0,   64'hFFFFFFFF80000000, 64'h0,  3'd4, 1'b0);
    t64[1]  = mk(32'h00001017, 64'h10,  64'h1000,             64'h1010, 3'd4, 1'b0);
    t64[2]  = mk(32'hFE001063, 64'h100, 64'hFFFFFFFFFFFFF7E0, 64'hFFFFFFFFFFFFF8E0, 3'd3, 1'b0);
    t64[3]  = mk(32'hFFFFFFFF, 64'h0,   64'h0,                64'h0,  3'd7, 1'b1);

    rst = 1'b1;
    in_valid32 = 1'b0; in32 = '0; pc32 = '0; out_ready32 = 1'b1;
    in_valid64 = 1'b0; in64 = '0; pc64 = '0; out_ready64 = 1'b1;
    cur32 = t32[0]; cur64 = t64[0];
    step();
    step();

    // Reset state
    chk("rst out_valid", 64'(out_valid32), 64'd0);
    chk("rst out", 64'(out32), 64'd0);
    chk("rst target", 64'(tgt32), 64'd0);
    chk("rst fmt", 64'(fmt32), 64'd0);
    chk("rst illegal", 64'(out_illegal32), 64'd0);
    chk("rst cnt", 64'(cnt32), 64'd0);
    chk("rst in_ready", 64'(in_ready32), 64'd0);
    chk("rst x64 out_valid", 64'(out_valid64), 64'd0);
    chk("rst x64 in_ready", 64'(in_ready64), 64'd0);
    rst = 1'b0;
    #1;
    chk("release in_ready", 64'(in_ready32), 64'd1);
    chk("release x64 in_ready", 64'(in_ready64), 64'd1);

    // One-cycle latency
    drive32(t32[0]);
    step();
    in_valid32 = 1'b0;
    chk("latency out_valid", 64'(out_valid32), 64'd1);
    chk("latency out", 64'(out32), 64'hFFFFFFFF);
    chk("latency fmt", 64'(fmt32), 64'd1);
    step();

    // Table stream, back-to-back
    ic = 0;
    for (int i = 1; i < 15; i++) begin
      send32(t32[i]);
      if (t32[i].ill) ic++;
      chk("x32 illegal_cnt", 64'(cnt32), 64'(ic));
    end
    wait_empty();

    ic = 0;
    for (int i = 0; i < 4; i++) begin
      send64(t64[i]);
      if (t64[i].ill) ic++;
      chk("x64 illegal_cnt", 64'(cnt64), 64'(ic));
    end
    wait_empty();

    // Saturation with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      send64(t64[3]);
      if (ic < 3) ic++;
      chk("x64 cnt saturate", 64'(cnt64), 64'(ic));
    end
    wait_empty();

    // Backpressure: A main, B skid, C held
    out_ready32 = 1'b0;
    send32(t32[11]);
    send32(t32[12]);
    chk("bp in_ready full", 64'(in_ready32), 64'd0);
    chk("bp out_valid", 64'(out_valid32), 64'd1);
    drive32(t32[13]);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp in_ready held", 64'(in_ready32), 64'd0);
      chk("bp out stable", 64'(out32), 64'(t32[11].imm[31:0]));
      chk("bp target stable", 64'(tgt32), 64'(t32[11].tgt[31:0]));
    end
    out_ready32 = 1'b1;
    step();
    chk("bp no accept during skid move", 64'(acc32), 64'd0);
    n = 0;
    while (!acc32 && n < 10) begin step(); n++; end
    if (!acc32) bound_fail("bp accept C");
    in_valid32 = 1'b0;
    wait_empty();
    step();
    chk("bp idle out_valid", 64'(out_valid32), 64'd0);

    // Reset with both entries full
    out_ready32 = 1'b0;
    out_ready64 = 1'b0;
    send32(t32[6]);
    send32(t32[4]);
    send64(t64[1]);
    chk("mid full in_ready", 64'(in_ready32), 64'd0);
    chk("mid cnt before", 64'(cnt32), 64'(ic == 3 ? 3 : 3));
    rst = 1'b1;
    #1;
    chk("mid x64 in_ready in reset", 64'(in_ready64), 64'd0);
    step();
    chk("mid out_valid", 64'(out_valid32), 64'd0);
    chk("mid out", 64'(out32), 64'd0);
    chk("mid cnt", 64'(cnt32), 64'd0);
    chk("mid x64 cnt", 64'(cnt64), 64'd0);
    chk("mid x64 out_valid", 64'(out_valid64), 64'd0);
    chk("mid in_ready in reset", 64'(in_ready32), 64'd0);
    rst = 1'b0;
    q32.delete();
    q64.delete();
    #1;
    chk("mid in_ready after", 64'(in_ready32), 64'd1);
    out_ready32 = 1'b1;
    out_ready64 = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("mid no stale output", 64'(out_valid32), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
